// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
// Holds the per-channel FSM encoding, mode encodings and the next-state/tick decode helpers.
package edge_det_pkg;

    typedef enum logic [1:0] {
        ZERO = 2'b00,
        RISE = 2'b01,
        ONE  = 2'b10,
        FALL = 2'b11
    } state_t;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    function automatic state_t next_state(input state_t cur, input logic filt);
        state_t nxt;
        case (cur)
            ZERO:    nxt = filt ? RISE : ZERO;
            RISE:    nxt = filt ? ONE  : FALL;
            ONE:     nxt = filt ? ONE  : FALL;
            FALL:    nxt = filt ? RISE : ZERO;
            default: nxt = ZERO;
        endcase
        return nxt;
    endfunction

    // mode[0] enables rising events, mode[1] enables falling events
    function automatic logic tick_decode(input state_t st, input logic [1:0] mode);
        return ((st == RISE) && mode[0]) || ((st == FALL) && mode[1]);
    endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One edge-detector channel: optional 2-flop synchronizer, level debounce filter,
// 4-state Moore edge FSM and mode-masked tick decode. Macro EDGE_SYNC_EN adds the synchronizer.
module edge_det_chan
    import edge_det_pkg::*;
#(
    parameter int DEB_CNT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lvl,
    input  logic [1:0] mode,
    output logic       edge_tick
);

    localparam int CW = (DEB_CNT > 0) ? $clog2(DEB_CNT + 1) : 1;
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CNT);

    logic          lvl_s;
    logic          filt_r;
    logic [CW-1:0] cnt_r;
    state_t        state_r;

`ifdef EDGE_SYNC_EN
    logic sync1_r;
    logic sync2_r;

    // Two-stage synchronizer for asynchronous level inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= lvl;
            sync2_r <= sync1_r;
        end
    end

    assign lvl_s = sync2_r;
`else
    assign lvl_s = lvl;
`endif

    // Debounce: a new level is accepted only after DEB_CNT+1 consecutive samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_r <= 1'b0;
            cnt_r  <= '0;
        end else if ((lvl_s != filt_r) && (cnt_r == DEB_MAX)) begin
            filt_r <= lvl_s;
            cnt_r  <= '0;
        end else if (lvl_s != filt_r) begin
            cnt_r  <= cnt_r + CW'(1);
        end else begin
            cnt_r  <= '0;
        end
    end

    // Edge FSM tracks the filtered level regardless of mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ZERO;
        end else begin
            state_r <= next_state(state_r, filt_r);
        end
    end

    // Moore tick decode from registered state, masked by the live mode
    always_comb begin
        edge_tick = tick_decode(state_r, mode);
    end

endmodule

// File: rtl/multi_edge_detector.sv
// N independent debounced edge-detector channels with sticky pending flags and an OR interrupt.
// Define EDGE_SYNC_EN to synchronize asynchronous lvl inputs inside each channel.
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int N       = 4,
    parameter int DEB_CNT = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   lvl,
    input  logic [2*N-1:0] mode,
    input  logic [N-1:0]   clr,
    output logic [N-1:0]   edge_tick,
    output logic [N-1:0]   pend,
    output logic           irq
);

    logic [N-1:0] tick_s;
    logic [N-1:0] pend_r;

    for (genvar i = 0; i < N; i++) begin : g_chan
        edge_det_chan #(
            .DEB_CNT(DEB_CNT)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .lvl      (lvl[i]),
            .mode     (mode[2*i+1:2*i]),
            .edge_tick(tick_s[i])
        );
    end

    // Sticky pending flags; a new event wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= '0;
        end else begin
            pend_r <= tick_s | (pend_r & ~clr);
        end
    end

    assign edge_tick = tick_s;
    assign pend      = pend_r;
    assign irq       = |pend_r;

endmodule
